// File: rtl/riscv_pkg.sv
`default_nettype none
// =============================================================================
// riscv_pkg : shared ALU op codes, branch condition codes and EX FSM states.
// Rev 1.0
// =============================================================================
package riscv_pkg;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;
    localparam logic [3:0] c_ALU_MUL  = 4'd10;

    localparam logic [2:0] c_BR_BEQ  = 3'b000;
    localparam logic [2:0] c_BR_BNE  = 3'b001;
    localparam logic [2:0] c_BR_BLT  = 3'b100;
    localparam logic [2:0] c_BR_BGE  = 3'b101;
    localparam logic [2:0] c_BR_BLTU = 3'b110;
    localparam logic [2:0] c_BR_BGEU = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_alu.sv
`default_nettype none
// =============================================================================
// riscv_alu : single-cycle integer ALU and branch comparator.
// Rev 1.0
// =============================================================================
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [3:0]           op_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [2:0]           cond_i,
    input  logic [WORD_SIZE-1:0] cmp_b_i,
    output logic [WORD_SIZE-1:0] result_o,
    output logic                 cond_true_o
);
    localparam int SW = $clog2(WORD_SIZE);

    logic [SW-1:0] w_shamt;
    logic          w_slt;
    logic          w_sltu;

    assign w_shamt = b_i[SW-1:0];
    assign w_slt   = $signed(a_i) < $signed(b_i);
    assign w_sltu  = a_i < b_i;

    // MUL is handled by the iterative unit in the stage; here it yields 0
    always_comb begin
        result_o = '0;
        case (op_i)
            c_ALU_ADD:  result_o = a_i + b_i;
            c_ALU_SUB:  result_o = a_i - b_i;
            c_ALU_AND:  result_o = a_i & b_i;
            c_ALU_OR:   result_o = a_i | b_i;
            c_ALU_XOR:  result_o = a_i ^ b_i;
            c_ALU_SLL:  result_o = a_i << w_shamt;
            c_ALU_SRL:  result_o = a_i >> w_shamt;
            c_ALU_SRA:  result_o = $unsigned($signed(a_i) >>> w_shamt);
            c_ALU_SLT:  result_o = {{(WORD_SIZE-1){1'b0}}, w_slt};
            c_ALU_SLTU: result_o = {{(WORD_SIZE-1){1'b0}}, w_sltu};
            default:    result_o = '0;
        endcase
    end

    always_comb begin
        cond_true_o = 1'b0;
        case (cond_i)
            c_BR_BEQ:  cond_true_o = (a_i == cmp_b_i);
            c_BR_BNE:  cond_true_o = (a_i != cmp_b_i);
            c_BR_BLT:  cond_true_o = ($signed(a_i) <  $signed(cmp_b_i));
            c_BR_BGE:  cond_true_o = ($signed(a_i) >= $signed(cmp_b_i));
            c_BR_BLTU: cond_true_o = (a_i <  cmp_b_i);
            c_BR_BGEU: cond_true_o = (a_i >= cmp_b_i);
            default:   cond_true_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_ex_stage.sv
`default_nettype none
// =============================================================================
// riscv_ex_stage : execute stage with operand forwarding, branch resolution,
//                  shift-add multiplier and an elastic output register.
// Rev 1.0
// =============================================================================
module riscv_ex_stage
    import riscv_pkg::*;
#(
    parameter int  WORD_SIZE     = 32,
    parameter int  REGFILE_COUNT = 32,
    parameter bit  MUL_EN        = 1'b1,
    localparam int AW            = $clog2(REGFILE_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WORD_SIZE-1:0] pc_i,
    input  logic [WORD_SIZE-1:0] rs1_data_i,
    input  logic [WORD_SIZE-1:0] rs2_data_i,
    input  logic [WORD_SIZE-1:0] imm_i,
    input  logic [AW-1:0]        rs1_addr_i,
    input  logic [AW-1:0]        rs2_addr_i,
    input  logic [AW-1:0]        rd_addr_i,
    input  logic [3:0]           alu_op_i,
    input  logic                 alu_src_i,
    input  logic                 branch_i,
    input  logic                 jump_i,
    input  logic                 jalr_i,
    input  logic [2:0]           br_cond_i,
    input  logic                 mem_wen_i,
    input  logic                 wb_wen_i,
    input  logic [AW-1:0]        mem_rd_i,
    input  logic [AW-1:0]        wb_rd_i,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    input  logic [WORD_SIZE-1:0] wb_data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] alu_out_o,
    output logic [WORD_SIZE-1:0] rs2_data_o,
    output logic [AW-1:0]        rd_addr_o,
    output logic                 zero_o,
    output logic                 br_taken_o,
    output logic [WORD_SIZE-1:0] br_target_o
);
    localparam int CW = $clog2(WORD_SIZE);

    ex_state_e            r_state;
    logic [CW-1:0]        r_cnt;
    logic [WORD_SIZE-1:0] r_mcand;
    logic [WORD_SIZE-1:0] r_mplier;
    logic [WORD_SIZE-1:0] r_acc;
    logic [AW-1:0]        r_mul_rd;
    logic [WORD_SIZE-1:0] r_mul_rs2;

    logic [WORD_SIZE-1:0] w_a;
    logic [WORD_SIZE-1:0] w_rs2;
    logic [WORD_SIZE-1:0] w_b;
    logic [WORD_SIZE-1:0] w_alu_res;
    logic [WORD_SIZE-1:0] w_result;
    logic [WORD_SIZE-1:0] w_jalr_sum;
    logic [WORD_SIZE-1:0] w_br_target;
    logic [WORD_SIZE-1:0] w_acc_next;
    logic                 w_cond;
    logic                 w_br_taken;
    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_mul_last;

    // MEM stage wins over WB; x0 is never forwarded
    function automatic logic [WORD_SIZE-1:0] fwd_sel(
        input logic [AW-1:0]        addr,
        input logic [WORD_SIZE-1:0] id_data,
        input logic                 mem_wen,
        input logic [AW-1:0]        mem_rd,
        input logic [WORD_SIZE-1:0] mem_data,
        input logic                 wb_wen,
        input logic [AW-1:0]        wb_rd,
        input logic [WORD_SIZE-1:0] wb_data
    );
        if (mem_wen && mem_rd == addr && addr != '0) return mem_data;
        if (wb_wen && wb_rd == addr && addr != '0)   return wb_data;
        return id_data;
    endfunction

    assign w_a   = fwd_sel(rs1_addr_i, rs1_data_i, mem_wen_i, mem_rd_i, mem_data_i,
                           wb_wen_i, wb_rd_i, wb_data_i);
    assign w_rs2 = fwd_sel(rs2_addr_i, rs2_data_i, mem_wen_i, mem_rd_i, mem_data_i,
                           wb_wen_i, wb_rd_i, wb_data_i);
    assign w_b   = alu_src_i ? imm_i : w_rs2;

    riscv_alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .op_i        (alu_op_i),
        .a_i         (w_a),
        .b_i         (w_b),
        .cond_i      (br_cond_i),
        .cmp_b_i     (w_rs2),
        .result_o    (w_alu_res),
        .cond_true_o (w_cond)
    );

    assign w_result    = jump_i ? (pc_i + WORD_SIZE'(4)) : w_alu_res;
    assign w_br_taken  = jump_i | (branch_i & w_cond);
    assign w_jalr_sum  = w_a + imm_i;
    assign w_br_target = jalr_i ? {w_jalr_sum[WORD_SIZE-1:1], 1'b0} : (pc_i + imm_i);

    assign ready_o    = (r_state == ST_IDLE) && (!valid_o || ready_i);
    assign w_accept   = valid_i && ready_o;
    assign w_is_mul   = MUL_EN && (alu_op_i == c_ALU_MUL) && !jump_i;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == CW'(WORD_SIZE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_mul_rd    <= '0;
            r_mul_rs2   <= '0;
            valid_o     <= 1'b0;
            br_taken_o  <= 1'b0;
            zero_o      <= 1'b0;
            alu_out_o   <= '0;
            rs2_data_o  <= '0;
            br_target_o <= '0;
            rd_addr_o   <= '0;
        end else if (flush_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            valid_o    <= 1'b0;
            br_taken_o <= 1'b0;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_mul_last) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                valid_o    <= 1'b1;
                br_taken_o <= 1'b0;
                alu_out_o  <= w_acc_next;
                zero_o     <= (w_acc_next == '0);
                rd_addr_o  <= r_mul_rd;
                rs2_data_o <= r_mul_rs2;
            end
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state    <= ST_MUL;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_mcand    <= w_a;
                r_mplier   <= w_b;
                r_mul_rd   <= rd_addr_i;
                r_mul_rs2  <= w_rs2;
                valid_o    <= 1'b0;
                br_taken_o <= 1'b0;
            end else begin
                valid_o     <= 1'b1;
                br_taken_o  <= w_br_taken;
                alu_out_o   <= w_result;
                zero_o      <= (w_result == '0);
                rs2_data_o  <= w_rs2;
                rd_addr_o   <= rd_addr_i;
                br_target_o <= w_br_target;
            end
        end else if (ready_i) begin
            valid_o    <= 1'b0;
            br_taken_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_ex_stage.sv
`default_nettype none
// =============================================================================
// tb_riscv_ex_stage : directed and randomized checks of the execute stage.
// Rev 1.0
// =============================================================================
module tb_riscv_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, valid_i, ready_o;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]  alu_op_i;
    logic        alu_src_i, branch_i, jump_i, jalr_i;
    logic [2:0]  br_cond_i;
    logic        mem_wen_i, wb_wen_i;
    logic [4:0]  mem_rd_i, wb_rd_i;
    logic [31:0] mem_data_i, wb_data_i;
    logic        valid_o, ready_i;
    logic [31:0] alu_out_o, rs2_data_o, br_target_o;
    logic [4:0]  rd_addr_o;
    logic        zero_o, br_taken_o;

    int n_vec = 0;
    int n_err = 0;

    riscv_ex_stage #(.WORD_SIZE(32), .REGFILE_COUNT(32), .MUL_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .alu_op_i(alu_op_i),
        .alu_src_i(alu_src_i), .branch_i(branch_i), .jump_i(jump_i),
        .jalr_i(jalr_i), .br_cond_i(br_cond_i), .mem_wen_i(mem_wen_i),
        .wb_wen_i(wb_wen_i), .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i),
        .mem_data_i(mem_data_i), .wb_data_i(wb_data_i), .valid_o(valid_o),
        .ready_i(ready_i), .alu_out_o(alu_out_o), .rs2_data_o(rs2_data_o),
        .rd_addr_o(rd_addr_o), .zero_o(zero_o), .br_taken_o(br_taken_o),
        .br_target_o(br_target_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_ops();
        valid_i = 0; flush_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; alu_op_i = 0; alu_src_i = 0;
        branch_i = 0; jump_i = 0; jalr_i = 0; br_cond_i = 0; mem_wen_i = 0; wb_wen_i = 0;
        mem_rd_i = 0; wb_rd_i = 0; mem_data_i = 0; wb_data_i = 0;
    endtask

    // Cycles from accept until valid_o (1 = next cycle), plus ready_o-low samples seen
    task automatic wait_valid(output int lat, output int lows);
        lat = 1;
        lows = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) lows++;
            tick();
            lat++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] id);
        if (addr == 0) return id;
        if (mem_wen_i && mem_rd_i == addr) return mem_data_i;
        if (wb_wen_i && wb_rd_i == addr) return wb_data_i;
        return id;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        longint unsigned p;
        s = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a + (~b) + 1;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << s;
            6: return a >> s;
            7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            10: begin p = longint'(a) * longint'(b); return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b2, b, exp_res, exp_tgt, hold_out;
        logic        exp_taken;
        int          lat, lows, exp_lat, ctl;
        bit          seen;

        clr_ops();
        ready_i = 1;
        rst_ni  = 0;
        tick(); tick();
        // reset state
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_taken", 32'(br_taken_o), 0);
        chk("rst_zero", 32'(zero_o), 0);
        chk("rst_alu", alu_out_o, 0);
        chk("rst_rs2", rs2_data_o, 0);
        chk("rst_tgt", br_target_o, 0);
        chk("rst_rd", 32'(rd_addr_o), 0);
        rst_ni = 1;
        tick();
        chk("rst_ready", 32'(ready_o), 1);

        // ADD wrap to zero
        rs1_addr_i = 1; rs1_data_i = 32'hFFFF_FFFF; alu_src_i = 1; imm_i = 1; rd_addr_i = 7;
        valid_i = 1;
        tick();
        chk("add_valid", 32'(valid_o), 1);
        chk("add_out", alu_out_o, 0);
        chk("add_zero", 32'(zero_o), 1);
        chk("add_rd", 32'(rd_addr_o), 7);

        // forwarding priority, back-to-back ops
        rs1_addr_i = 5; rs1_data_i = 32'h55; mem_rd_i = 5; wb_rd_i = 5;
        mem_wen_i = 1; wb_wen_i = 1; mem_data_i = 32'h10; wb_data_i = 32'h20;
        tick();
        chk("fwd_mem", alu_out_o, 32'h11);
        mem_wen_i = 0;
        tick();
        chk("fwd_wb", alu_out_o, 32'h21);
        mem_wen_i = 1; rs1_addr_i = 0;
        tick();
        chk("fwd_x0", alu_out_o, 32'h56);
        clr_ops();

        // MUL latency and result
        rs1_addr_i = 1; rs2_addr_i = 2; rs1_data_i = 32'h0000_FFFF; rs2_data_i = 32'h0001_0001;
        alu_op_i = 10; rd_addr_i = 3; valid_i = 1;
        tick();
        valid_i = 0;
        wait_valid(lat, lows);
        chk("mul_lat", 32'(lat), 33);
        chk("mul_ready_low", 32'(lows), 32);
        chk("mul_out", alu_out_o, 32'hFFFF_FFFF);
        chk("mul_rs2", rs2_data_o, 32'h0001_0001);

        // BLT / BLTU / JAL / JALR
        clr_ops();
        rs1_addr_i = 1; rs2_addr_i = 2; rs1_data_i = 32'hFFFF_FFFE; rs2_data_i = 1;
        pc_i = 32'h100; imm_i = 32'h20; branch_i = 1; br_cond_i = 3'b100; valid_i = 1;
        tick();
        chk("blt_taken", 32'(br_taken_o), 1);
        chk("blt_tgt", br_target_o, 32'h120);
        br_cond_i = 3'b110;
        tick();
        chk("bltu_taken", 32'(br_taken_o), 0);
        branch_i = 0; jump_i = 1;
        tick();
        chk("jal_out", alu_out_o, 32'h104);
        chk("jal_taken", 32'(br_taken_o), 1);
        jalr_i = 1; rs1_data_i = 32'h1001; imm_i = 32'h10;
        tick();
        chk("jalr_tgt", br_target_o, 32'h1010);
        clr_ops();
        tick();
        chk("drain_valid", 32'(valid_o), 0);
        chk("drain_taken", 32'(br_taken_o), 0);

        // backpressure
        rs1_addr_i = 1; rs1_data_i = 32'hA5; alu_src_i = 1; imm_i = 32'h0F; alu_op_i = 2;
        valid_i = 1; ready_i = 0;
        tick();
        hold_out = alu_out_o;
        chk("bp_first", alu_out_o, 32'h05);
        alu_op_i = 4;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(ready_o), 0);
            tick();
            chk("bp_hold", alu_out_o, hold_out);
            chk("bp_valid", 32'(valid_o), 1);
        end
        ready_i = 1;
        #1;
        chk("bp_release_ready", 32'(ready_o), 1);
        tick();
        chk("bp_next", alu_out_o, 32'hAA);
        clr_ops();
        tick();

        // flush of a taken branch held under backpressure
        rs1_data_i = 32'h9; rs2_data_i = 32'h9; branch_i = 1; br_cond_i = 3'b000;
        valid_i = 1; ready_i = 0;
        tick();
        chk("fl_br_taken", 32'(br_taken_o), 1);
        valid_i = 0; flush_i = 1;
        tick();
        flush_i = 0; ready_i = 1;
        chk("fl_br_valid", 32'(valid_o), 0);
        chk("fl_br_cleared", 32'(br_taken_o), 0);

        // flush during MUL
        clr_ops();
        rs1_data_i = 32'h3; rs2_data_i = 32'h5; alu_op_i = 10; valid_i = 1;
        tick();
        valid_i = 0;
        for (int i = 0; i < 9; i++) tick();
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("fl_mul_valid", 32'(valid_o), 0);
        chk("fl_mul_ready", 32'(ready_o), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) seen = 1;
        end
        chk("fl_mul_no_result", 32'(seen), 0);

        // reset during MUL
        rs1_data_i = 32'h7; rs2_data_i = 32'h9; alu_op_i = 10; valid_i = 1;
        tick();
        valid_i = 0;
        for (int i = 0; i < 5; i++) tick();
        rst_ni = 0;
        #1;
        chk("rm_valid", 32'(valid_o), 0);
        chk("rm_alu", alu_out_o, 0);
        chk("rm_tgt", br_target_o, 0);
        chk("rm_rs2", rs2_data_o, 0);
        tick();
        rst_ni = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) seen = 1;
        end
        chk("rm_no_result", 32'(seen), 0);

        // randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            clr_ops();
            alu_op_i   = 4'($urandom_range(0, 11));
            rs1_addr_i = 5'($urandom_range(0, 3));
            rs2_addr_i = 5'($urandom_range(0, 3));
            rd_addr_i  = 5'($urandom_range(0, 31));
            mem_rd_i   = 5'($urandom_range(0, 3));
            wb_rd_i    = 5'($urandom_range(0, 3));
            mem_wen_i  = 1'($urandom_range(0, 1));
            wb_wen_i   = 1'($urandom_range(0, 1));
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            mem_data_i = $urandom; wb_data_i = $urandom;
            alu_src_i  = 1'($urandom_range(0, 1));
            imm_i      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            pc_i       = $urandom & 32'hFFFF_FFFC;
            br_cond_i  = 3'($urandom_range(0, 7));
            ctl        = int'($urandom_range(0, 5));
            branch_i   = (ctl == 1 || ctl == 2);
            jump_i     = (ctl == 3 || ctl == 4);
            jalr_i     = (ctl == 4);
            if ($urandom_range(0, 3) == 0) rs2_data_i = rs1_data_i;

            a         = ref_fwd(rs1_addr_i, rs1_data_i);
            b2        = ref_fwd(rs2_addr_i, rs2_data_i);
            b         = alu_src_i ? imm_i : b2;
            exp_res   = jump_i ? pc_i + 32'd4 : ref_alu(alu_op_i, a, b);
            exp_lat   = (alu_op_i == 10 && !jump_i) ? 33 : 1;
            exp_taken = jump_i || (branch_i && ref_cond(br_cond_i, a, b2));
            exp_tgt   = jalr_i ? ((a + imm_i) & ~32'h1) : pc_i + imm_i;

            valid_i = 1;
            chk("rnd_ready", 32'(ready_o), 1);
            tick();
            valid_i = 0;
            wait_valid(lat, lows);
            chk("rnd_lat", 32'(lat), 32'(exp_lat));
            chk("rnd_out", alu_out_o, exp_res);
            chk("rnd_zero", 32'(zero_o), 32'(exp_res == 0));
            chk("rnd_rs2", rs2_data_o, b2);
            chk("rnd_rd", 32'(rd_addr_o), 32'(rd_addr_i));
            if (exp_lat == 1) begin
                chk("rnd_taken", 32'(br_taken_o), 32'(exp_taken));
                chk("rnd_tgt", br_target_o, exp_tgt);
            end else begin
                chk("rnd_mul_taken", 32'(br_taken_o), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_ex_stage.md
RISCV_EX_STAGE -- requirements
Module: riscv_ex_stage

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 32, datapath width; REGFILE_COUNT, default 32, register count (address width AW = clog2(REGFILE_COUNT)); MUL_EN, default 1, enables the iterative multiplier.
REQ-002 Ports SHALL be:
clk_i  in  1  clock
rst_ni  in  1  asynchronous, active-low reset
flush_i  in  1  kill the in-flight operation and the output register
valid_i  in  1  ID→EX operation valid
ready_o  out  1  EX accepts the operation this cycle
pc_i, rs1_data_i, rs2_data_i, imm_i  in  WORD_SIZE  operands from ID
rs1_addr_i, rs2_addr_i, rd_addr_i  in  AW  register addresses
alu_op_i  in  4  operation code
alu_src_i  in  1  1: B operand = imm_i; 0: B operand = forwarded rs2
branch_i, jump_i, jalr_i  in  1  control-transfer type
br_cond_i  in  3  RISC-V funct3 branch condition
mem_wen_i, wb_wen_i  in  1  forwarding source valid
mem_rd_i, wb_rd_i  in  AW  forwarding destination
mem_data_i, wb_data_i  in  WORD_SIZE  forwarding data
valid_o  out  1  EX→MEM result valid
ready_i  in  1  MEM accepts the result
alu_out_o, rs2_data_o  out  WORD_SIZE  result; forwarded store data
rd_addr_o  out  AW  destination register
zero_o, br_taken_o  out  1  ALU result == 0; redirect the PC
br_target_o  out  WORD_SIZE  redirect address

Function
REQ-003 An operation SHALL be accepted when valid_i && ready_o is high at a rising clock edge.
REQ-004 Operand forwarding SHALL apply to rs1 and rs2 separately: if mem_wen_i && mem_rd_i == addr && addr != 0, use mem_data_i; else if wb_wen_i && wb_rd_i == addr && addr != 0, use wb_data_i; else use the ID data. MEM SHALL have priority over WB.
REQ-005 alu_op_i encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low WORD_SIZE bits of the product). All other codes SHALL produce 0.
REQ-006 Shift amounts SHALL use B[clog2(WORD_SIZE)-1:0]. Add and subtract SHALL wrap modulo 2^WORD_SIZE.
REQ-007 Branch conditions SHALL be: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Codes 010 and 011 SHALL never be taken.
REQ-008 br_taken_o SHALL be jump_i OR (branch_i AND condition true).
REQ-009 br_target_o SHALL be (A + imm_i) with bit 0 cleared when jalr_i is set; otherwise it SHALL be pc_i + imm_i.
REQ-010 For jump_i, alu_out_o SHALL be pc_i + 4.
REQ-011 A non-MUL operation SHALL have 1-cycle latency: its results register into the output stage at the accept edge.
REQ-012 FSM states SHALL be IDLE and MUL.
REQ-013 IDLE→MUL SHALL occur when a MUL op is accepted and MUL_EN = 1. The forwarded operands SHALL be latched at that edge.
REQ-014 MUL SHALL run a shift-add sequence of exactly WORD_SIZE cycles. MUL→IDLE SHALL occur on the last iteration, writing the product to the output stage.
REQ-015 When MUL_EN = 0, op 10 SHALL behave as an unknown code and produce 0.
REQ-016 ready_o SHALL be (state == IDLE) && (!valid_o || ready_i).
REQ-017 The output stage SHALL hold all outputs stable while valid_o && !ready_i.
REQ-018 When ready_i is high and no new result is produced, valid_o SHALL fall the next cycle.
REQ-019 flush_i SHALL take priority over every other event. At the next edge it SHALL clear valid_o and br_taken_o, force IDLE, and discard any accepted op, including a MUL in progress.
REQ-020 br_taken_o SHALL be qualified by valid_o; it SHALL never be high while valid_o is low.

Reset
REQ-021 While rst_ni is low, valid_o, br_taken_o and zero_o SHALL be 0; alu_out_o, rs2_data_o, br_target_o and rd_addr_o SHALL be 0; the FSM SHALL be in IDLE and the MUL counter SHALL be 0.
REQ-022 Reset asserted mid-MUL SHALL abort the multiply. No result SHALL be emitted after release.

Structure
REQ-023 The alu_op codes, branch condition codes and FSM state enum SHALL live in package riscv_pkg.
REQ-024 The combinational ALU SHALL be a sub-module riscv_alu. The multiplier FSM, forwarding logic and output register SHALL stay in riscv_ex_stage.

Verification
REQ-025 ADD, A=0xFFFFFFFF, B=1 → alu_out_o=0, zero_o=1, valid_o the cycle after accept.
REQ-026 rs1_addr=5, mem_rd=5, wb_rd=5, mem_data=0x10, wb_data=0x20, ADD imm 1 → alu_out_o=0x11. The same test with rs1_addr=0 → rs1_data_i+1.
REQ-027 MUL 0x0000FFFF × 0x00010001 → alu_out_o=0xFFFFFFFF. ready_o low for 32 cycles; valid_o 33 cycles after accept.
REQ-028 BLT rs1=0xFFFFFFFE, rs2=1, pc=0x100, imm=0x20 → br_taken_o=1, br_target_o=0x120. BLTU with the same operands → br_taken_o=0.
REQ-029 ready_i held low 3 cycles with valid_o=1 → outputs unchanged and ready_o=0. ready_i rising → the next op is accepted the same cycle.
REQ-030 flush_i at MUL cycle 10 → valid_o stays 0 and ready_o=1 the next cycle. rst_ni pulsed mid-MUL → all outputs 0.
